sdram_wr_drain: RTL and testbench

Downstream consumer of the write-data `fifo_sync` in the SDRAM controller. It watches the FIFO, requests a write-burst slot from the SDRAM command engine, and pops words into a fixed-length write burst. It generates the burst start address with region wrap-around, and masks beats with DQM whenever the FIFO runs dry mid-burst.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_wr_addr_gen.sv | 80 ++++++++
 rtl/sdram_wr_drain.sv | 174 +++++++++++++++++
 tb/tb_sdram_wr_drain.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
//   Shared definitions for the SDRAM write-drain path.
//   - wr_state_t     : drain FSM state encoding (IDLE / REQ / DATA)
//   - DEF_BURST_LEN  : default beats per write burst
//   - DEF_REGION_WORDS : default circular region size in words
//   - DQM_MASKED     : DQM level that suppresses a beat
//   - cnt_w()        : counter width helper that never returns 0
// ---------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } wr_state_t;

  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_REGION_WORDS = 256;

  localparam logic DQM_MASKED = 1'b1;

  // Width needed to count 0..n-1; a single bit when n is 1 so that
  // counters never collapse to zero-width vectors.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// sdram_wr_addr_gen
//   Burst start-address generator for the write-drain path. Holds the
//   current burst address and the region base, advances by one burst after
//   every completed burst and wraps back to the base at the region end.
//   A base load while a burst is in flight is parked and applied when the
//   burst completes, taking priority over the normal advance.
//
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   asynchronous active-low reset
//   cfg_base   in   [ADDR_W] new region base
//   cfg_load   in   one-cycle pulse loading cfg_base
//   in_idle    in   drain FSM is in IDLE (load may apply at once)
//   burst_done in   final beat of a burst; next cycle is IDLE
//   wr_addr    out  [ADDR_W] current burst start address
// ---------------------------------------------------------------------------
module sdram_wr_addr_gen
  import sdram_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int REGION_WORDS = DEF_REGION_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_load,
  input  logic              in_idle,
  input  logic              burst_done,
  output logic [ADDR_W-1:0] wr_addr
);

  // Both constants are taken modulo 2^ADDR_W, matching the address math.
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(REGION_WORDS);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] pend_base_q;
  logic              pend_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] region_end;

  assign addr_inc   = wr_addr + STEP;
  assign region_end = base_q + SPAN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      base_q      <= '0;
      pend_base_q <= '0;
      pend_q      <= 1'b0;
    end else if (burst_done) begin
      // IDLE-entry cycle: a load (parked earlier or arriving right now)
      // replaces the post-burst advance entirely.
      pend_q <= 1'b0;
      if (cfg_load) begin
        base_q  <= cfg_base;
        wr_addr <= cfg_base;
      end else if (pend_q) begin
        base_q  <= pend_base_q;
        wr_addr <= pend_base_q;
      end else if (addr_inc == region_end) begin
        wr_addr <= base_q;
      end else begin
        wr_addr <= addr_inc;
      end
    end else if (cfg_load) begin
      if (in_idle) begin
        base_q  <= cfg_base;
        wr_addr <= cfg_base;
      end else begin
        // Keep wr_addr stable for the request/burst in progress.
        pend_q      <= 1'b1;
        pend_base_q <= cfg_base;
      end
    end
  end

endmodule

// File: rtl/sdram_wr_drain.sv
// ---------------------------------------------------------------------------
// sdram_wr_drain
//   Drains the write-data FIFO into fixed-length SDRAM write bursts. Waits
//   for the FIFO to stay non-empty for HOLDOFF cycles, requests a burst slot,
//   and on grant pops one word per beat. Beats for which no word could be
//   popped (FIFO ran dry) are sent with DQM asserted and zero data.
//
// Handshake: req is held high with a stable wr_addr until a single-cycle
//   gnt; the WRITE is issued in the gnt cycle and beats follow on the next
//   BURST_LEN cycles with no backpressure. gnt outside REQ is ignored.
//
// Ports:
//   clk, rst_n              clock (posedge), async active-low reset
//   fifo_empty              in   FIFO empty flag
//   fifo_rd_data [WIDTH]    in   FIFO registered read data
//   fifo_rd_en              out  pop strobe (never while fifo_empty)
//   cfg_base [ADDR_W]       in   region base
//   cfg_load                in   load pulse for cfg_base
//   req                     out  burst request
//   gnt                     in   burst grant (one cycle)
//   wr_addr [ADDR_W]        out  burst start address
//   wr_valid                out  beat valid
//   wr_data [WIDTH]         out  beat data
//   wr_dqm                  out  beat masked
//   wr_last                 out  final beat of burst
//   busy                    out  FSM not in IDLE
//   dbg_state               out  current FSM state
// ---------------------------------------------------------------------------
module sdram_wr_drain
  import sdram_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int ADDR_W       = 12,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int REGION_WORDS = DEF_REGION_WORDS,
  parameter int HOLDOFF      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_load,
  output logic              req,
  input  logic              gnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_dqm,
  output logic              wr_last,
  output logic              busy,
  output wr_state_t         dbg_state
);

  localparam int BW = cnt_w(BURST_LEN);
  localparam int HW = cnt_w(HOLDOFF);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  wr_state_t     state;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_nxt;
  logic          req_q;
  logic          busy_q;
  logic          valid_q;
  logic          last_q;
  logic          popped;
  logic          pop;
  logic          burst_done;

  assign beat_nxt   = beat_cnt + 1'b1;
  assign burst_done = (state == ST_DATA) && (beat_cnt == LAST_BEAT);

  // Grant cycle fetches beat 0; DATA beat k fetches beat k+1. The final
  // DATA beat has nothing left to fetch. Guarded by fifo_empty so a dry
  // FIFO is never popped.
  assign pop = !fifo_empty &&
               (((state == ST_REQ) && gnt) ||
                ((state == ST_DATA) && (beat_cnt != LAST_BEAT)));

  assign fifo_rd_en = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      beat_cnt <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fifo_empty) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_REQ;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_REQ: begin
          if (gnt) begin
            state    <= ST_DATA;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            beat_cnt <= '0;
            last_q   <= (LAST_BEAT == '0);
          end
        end
        ST_DATA: begin
          if (beat_cnt == LAST_BEAT) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            hold_cnt <= '0;
          end else begin
            beat_cnt <= beat_nxt;
            last_q   <= (beat_nxt == LAST_BEAT);
          end
        end
        default: begin
          state   <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Remembers whether the word on fifo_rd_data this cycle is a fresh pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      popped <= 1'b0;
    end else begin
      popped <= pop;
    end
  end

  assign req       = req_q;
  assign busy      = busy_q;
  assign wr_valid  = valid_q;
  assign wr_last   = last_q;
  assign dbg_state = state;

  // FIFO output register is the timing source; data passes straight through.
  assign wr_data = popped ? fifo_rd_data : '0;
  assign wr_dqm  = valid_q & (popped ? ~DQM_MASKED : DQM_MASKED);

  sdram_wr_addr_gen #(
    .ADDR_W       (ADDR_W),
    .BURST_LEN    (BURST_LEN),
    .REGION_WORDS (REGION_WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_base   (cfg_base),
    .cfg_load   (cfg_load),
    .in_idle    (state == ST_IDLE),
    .burst_done (burst_done),
    .wr_addr    (wr_addr)
  );

endmodule

// File: tb/tb_sdram_wr_drain.sv
// ---------------------------------------------------------------------------
// tb_sdram_wr_drain
//   Bench for sdram_wr_drain with BURST_LEN=4, REGION_WORDS=8, HOLDOFF=8.
//   A queue-based FIFO with a registered read port feeds the DUT; a separate
//   reference queue plus an address model predict beats and addresses.
// ---------------------------------------------------------------------------
module tb_sdram_wr_drain;
  import sdram_pkg::*;

  localparam int BL     = 4;
  localparam int REGION = 8;
  localparam int HOLD   = 8;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en;
  logic [11:0] cfg_base;
  logic        cfg_load;
  logic        req;
  logic        gnt;
  logic [11:0] wr_addr;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_dqm;
  logic        wr_last;
  logic        busy;
  wr_state_t   dbg_state;

  int checks   = 0;
  int failures = 0;

  // FIFO storage (bench side)
  logic [7:0] fifo_q[$];
  int         fifo_cnt = 0;
  int         rd_viol  = 0;
  logic       fifo_hide;
  logic       push_en;
  logic [7:0] push_val;

  // Reference model
  logic [7:0]  mdl_q[$];
  logic [11:0] exp_addr;
  logic [11:0] exp_base;
  logic [11:0] pend_addr;
  bit          pend_v;

  sdram_wr_drain #(
    .WIDTH        (8),
    .ADDR_W       (12),
    .BURST_LEN    (BL),
    .REGION_WORDS (REGION),
    .HOLDOFF      (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .cfg_base     (cfg_base),
    .cfg_load     (cfg_load),
    .req          (req),
    .gnt          (gnt),
    .wr_addr      (wr_addr),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_dqm       (wr_dqm),
    .wr_last      (wr_last),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model ----------------
  assign fifo_empty = (fifo_cnt == 0) || fifo_hide;

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    if (push_en) fifo_q.push_back(push_val);
    fifo_cnt <= fifo_q.size();
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [7:0] v);
    push_val = v;
    push_en  = 1'b1;
    @(negedge clk);
    push_en  = 1'b0;
    mdl_q.push_back(v);
  endtask

  task automatic load_cfg(input logic [11:0] v);
    cfg_base = v;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    exp_base = v;
    exp_addr = v;
    checks++;
    if (wr_addr !== v) begin
      failures++;
      $display("FAIL idle_load wr_addr got=%h exp=%h", wr_addr, v);
    end
  endtask

  // One full request/grant/burst. Optional cfg_load at a beat, optional
  // asynchronous reset at a beat (abort).
  task automatic run_burst(input int gnt_dly, input int load_beat,
                           input logic [11:0] load_val, input int abort_beat);
    int          waited;
    int          n_avail;
    int          n_pop;
    bit          stable;
    logic [11:0] a0;
    logic [11:0] nxt;
    logic [8:0]  exp_q[$];
    logic [8:0]  e;
    waited = 0;
    while (!req && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!req) begin
      failures++;
      $display("FAIL req_timeout got=%0b exp=1 after %0d cycles", req, waited);
      return;
    end
    checks++;
    if (wr_addr !== exp_addr) begin
      failures++;
      $display("FAIL burst_addr got=%h exp=%h", wr_addr, exp_addr);
    end
    a0 = wr_addr;
    stable = 1'b1;
    for (int d = 0; d < gnt_dly; d++) begin
      @(negedge clk);
      if (wr_addr !== a0 || req !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL req_hold got=%h/%0b exp=%h/1", wr_addr, req, a0);
    end
    // Expected beats: available words in FIFO order, then masked zeros.
    n_avail = mdl_q.size();
    for (int b = 0; b < BL; b++) begin
      if (b < n_avail) exp_q.push_back({1'b0, mdl_q[b]});
      else             exp_q.push_back({1'b1, 8'h00});
    end
    gnt = 1'b1;
    for (int b = 0; b < BL; b++) begin
      @(negedge clk);
      gnt      = 1'b0;
      cfg_load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (wr_valid !== 1'b1 || wr_dqm !== e[8] || wr_data !== e[7:0] ||
          wr_last !== (b == BL - 1)) begin
        failures++;
        $display("FAIL beat%0d got v=%0b dqm=%0b d=%h last=%0b exp v=1 dqm=%0b d=%h last=%0b",
                 b, wr_valid, wr_dqm, wr_data, wr_last, e[8], e[7:0], (b == BL - 1));
      end
      if (b == load_beat) begin
        cfg_base  = load_val;
        cfg_load  = 1'b1;
        pend_v    = 1'b1;
        pend_addr = load_val;
      end
      if (b == abort_beat) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_rd_en, req, wr_valid, wr_dqm, wr_last, busy} !== 6'b0 ||
            wr_data !== 8'h00 || wr_addr !== 12'h000) begin
          failures++;
          $display("FAIL abort_outputs got ctl=%b d=%h a=%h exp ctl=000000 d=00 a=000",
                   {fifo_rd_en, req, wr_valid, wr_dqm, wr_last, busy}, wr_data, wr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_pop = (n_avail < b + 1) ? n_avail : b + 1;
        for (int i = 0; i < n_pop; i++) void'(mdl_q.pop_front());
        exp_addr = 12'h000;
        exp_base = 12'h000;
        pend_v   = 1'b0;
        checks++;
        if (fifo_cnt !== mdl_q.size()) begin
          failures++;
          $display("FAIL abort_fifo_level got=%0d exp=%0d", fifo_cnt, mdl_q.size());
        end
        return;
      end
    end
    @(negedge clk);
    cfg_load = 1'b0;
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_last !== 1'b0) begin
      failures++;
      $display("FAIL burst_end got v=%0b busy=%0b last=%0b exp 0/0/0", wr_valid, busy, wr_last);
    end
    n_pop = (n_avail < BL) ? n_avail : BL;
    for (int i = 0; i < n_pop; i++) void'(mdl_q.pop_front());
    checks++;
    if (fifo_cnt !== mdl_q.size()) begin
      failures++;
      $display("FAIL fifo_level got=%0d exp=%0d", fifo_cnt, mdl_q.size());
    end
    if (pend_v) begin
      exp_base = pend_addr;
      exp_addr = pend_addr;
      pend_v   = 1'b0;
    end else begin
      nxt = exp_addr + 12'(BL);
      exp_addr = (nxt == exp_base + 12'(REGION)) ? exp_base : nxt;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_rd_en, req, wr_valid, wr_dqm, wr_last, busy} !== 6'b0 ||
        wr_data !== 8'h00 || wr_addr !== 12'h000 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_values got ctl=%b d=%h a=%h st=%0d exp ctl=000000 d=00 a=000 st=0",
               {fifo_rd_en, req, wr_valid, wr_dqm, wr_last, busy}, wr_data, wr_addr, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gnt_ignored;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_valid !== 1'b0 || busy !== 1'b0 || req !== 1'b0 || fifo_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL gnt_ignored got v=%0b busy=%0b req=%0b rd=%0b exp 0/0/0/0",
                 wr_valid, busy, req, fifo_rd_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic;
    load_cfg(12'h010);
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    run_burst(2, -1, 12'h000, -1);
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_drained fifo_empty got=%0b exp=1", fifo_empty);
    end
  endtask

  task automatic test_dry_fifo;
    push_word(8'hA1);
    push_word(8'hA2);
    run_burst(1, -1, 12'h000, -1);
  endtask

  task automatic test_wrap;
    load_cfg(12'h0F8);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < BL; w++) push_word(8'($urandom_range(0, 255)));
      run_burst(1, -1, 12'h000, -1);
    end
  endtask

  task automatic test_holdoff;
    bit seen;
    int k;
    fifo_hide = 1'b1;
    for (int w = 0; w < BL; w++) push_word(8'($urandom_range(0, 255)));
    seen = 1'b0;
    for (int p = 0; p < 8; p++) begin
      fifo_hide = (p % 2 == 1);
      repeat (3) begin
        @(negedge clk);
        if (req) seen = 1'b1;
      end
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL holdoff_toggle req got=1 exp=0");
    end
    fifo_hide = 1'b0;
    k = 0;
    while (!req && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== HOLD) begin
      failures++;
      $display("FAIL holdoff_latency got=%0d exp=%0d", k, HOLD);
    end
    run_burst(0, -1, 12'h000, -1);
  endtask

  task automatic test_cfg_mid_burst;
    for (int w = 0; w < BL; w++) push_word(8'($urandom_range(0, 255)));
    run_burst(0, 1, 12'h200, -1);
    checks++;
    if (wr_addr !== 12'h200) begin
      failures++;
      $display("FAIL pending_load wr_addr got=%h exp=200", wr_addr);
    end
    for (int w = 0; w < BL; w++) push_word(8'($urandom_range(0, 255)));
    run_burst(0, -1, 12'h000, -1);
  endtask

  task automatic test_back_to_back;
    int k;
    for (int w = 0; w < 2 * BL; w++) push_word(8'($urandom_range(0, 255)));
    run_burst(0, -1, 12'h000, -1);
    k = 0;
    while (!req && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== HOLD) begin
      failures++;
      $display("FAIL next_req_latency got=%0d exp=%0d", k, HOLD);
    end
    run_burst(0, -1, 12'h000, -1);
  endtask

  task automatic test_reset_mid_burst;
    for (int w = 0; w < 6; w++) push_word(8'($urandom_range(0, 255)));
    run_burst(0, -1, 12'h000, 2);
    run_burst(1, -1, 12'h000, -1);
  endtask

  task automatic test_random;
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) push_word(8'($urandom_range(0, 255)));
      run_burst($urandom_range(0, 3), -1, 12'h000, -1);
    end
    for (int d = 0; d < 4 && mdl_q.size() > 0; d++) run_burst(0, -1, 12'h000, -1);
    checks++;
    if (rd_viol !== 0) begin
      failures++;
      $display("FAIL pop_while_empty got=%0d exp=0", rd_viol);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n     = 1'b0;
    gnt       = 1'b0;
    cfg_load  = 1'b0;
    cfg_base  = 12'h000;
    fifo_hide = 1'b0;
    push_en   = 1'b0;
    push_val  = 8'h00;
    exp_addr  = 12'h000;
    exp_base  = 12'h000;
    pend_addr = 12'h000;
    pend_v    = 1'b0;

    test_reset();
    test_gnt_ignored();
    test_basic();
    test_dry_fifo();
    test_wrap();
    test_holdoff();
    test_cfg_mid_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
